// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths, NOP encoding and entry type for the fetch queue
package fetch_queue_pkg;

   localparam int INSTRUCTION_WIDTH  = 32;
   localparam int SUPER_SCALAR_WIDTH = 4;
   localparam int FQ_DEPTH           = 16;

   // Width of a lane count 0..SUPER_SCALAR_WIDTH.
   localparam int LANE_CNT_W = $clog2(SUPER_SCALAR_WIDTH + 1);

   // Architectural NOP shown on lanes that hold no instruction; fetch uses the same value.
   localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = 32'hD503201F;

   typedef struct packed {
      logic [INSTRUCTION_WIDTH-1:0] instr;
      logic [63:0]                  pc;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// rtl/fetch_queue_storage.sv - circular entry array with per-lane write and read ports
module fetch_queue_storage
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH
) (
   input  logic                                                clk_i,
   input  logic [SUPER_SCALAR_WIDTH-1:0]                       wr_en_i,
   input  logic [$clog2(DEPTH)-1:0]                            wr_base_i,
   input  logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] wr_instrs_i,
   input  logic [63:0]                                         wr_pc_i,
   input  logic [$clog2(DEPTH)-1:0]                            rd_base_i,
   output logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] rd_instrs_o,
   output logic [SUPER_SCALAR_WIDTH-1:0][63:0]                 rd_pcs_o
);

   localparam int PTR_W = $clog2(DEPTH);

   fq_entry_t mem_q [DEPTH];

   logic [SUPER_SCALAR_WIDTH-1:0][PTR_W-1:0] wr_addr;
   logic [SUPER_SCALAR_WIDTH-1:0][PTR_W-1:0] rd_addr;

   // Lane i addresses base+i; pointer width makes the wrap modulo DEPTH implicit.
   always_comb begin
      for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
         wr_addr[i] = wr_base_i + PTR_W'(i);
         rd_addr[i] = rd_base_i + PTR_W'(i);
      end
   end

   // Each enabled lane writes its instruction with pc = group pc + 4*lane (64-bit wrap).
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
         if (wr_en_i[i]) begin
            mem_q[wr_addr[i]] <= '{instr: wr_instrs_i[i], pc: wr_pc_i + 64'(4 * i)};
         end
      end
   end

   // Read ports expose the W entries starting at the head pointer.
   always_comb begin
      for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
         rd_instrs_o[i] = mem_q[rd_addr[i]].instr;
         rd_pcs_o[i]    = mem_q[rd_addr[i]].pc;
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction buffer between fetch and decode with flush
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH
) (
   input  logic                                                clk_in,
   input  logic                                                rst_in,
   input  logic                                                flush_in,
   input  logic                                                fetch_valid_in,
   input  logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] fetch_instrs_in,
   input  logic [LANE_CNT_W-1:0]                               fetch_count_in,
   input  logic [63:0]                                         fetch_pc_in,
   output logic                                                fq_ready_out,
   output logic                                                decode_valid_out,
   output logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] decode_instrs_out,
   output logic [SUPER_SCALAR_WIDTH-1:0][63:0]                 decode_pcs_out,
   output logic [LANE_CNT_W-1:0]                               decode_count_out,
   input  logic                                                decode_ready_in,
   output logic [$clog2(DEPTH+1)-1:0]                          occupancy_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic                          enq_fire;
   logic                          deq_fire;
   logic [LANE_CNT_W-1:0]         enq_lanes;
   logic [LANE_CNT_W-1:0]         deq_lanes;
   logic [SUPER_SCALAR_WIDTH-1:0] wr_en;

   logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] rd_instrs;
   logic [SUPER_SCALAR_WIDTH-1:0][63:0]                 rd_pcs;

   fetch_queue_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .clk_i       (clk_in),
      .wr_en_i     (wr_en),
      .wr_base_i   (tail_q),
      .wr_instrs_i (fetch_instrs_in),
      .wr_pc_i     (fetch_pc_in),
      .rd_base_i   (head_q),
      .rd_instrs_o (rd_instrs),
      .rd_pcs_o    (rd_pcs)
   );

   // Handshakes and next pointers; ready only looks at registered count, so a
   // same-cycle dequeue never earns fetch extra room.
   always_comb begin
      fq_ready_out     = count_q <= CNT_W'(DEPTH - SUPER_SCALAR_WIDTH);
      decode_valid_out = count_q != '0;
      decode_count_out = (count_q >= CNT_W'(SUPER_SCALAR_WIDTH))
                         ? LANE_CNT_W'(SUPER_SCALAR_WIDTH)
                         : count_q[LANE_CNT_W-1:0];
      occupancy_out    = count_q;

      enq_fire = fetch_valid_in & fq_ready_out & ~flush_in;
      deq_fire = decode_valid_out & decode_ready_in & ~flush_in;

      enq_lanes = '0;
      if (enq_fire) begin
         // An out-of-range count is clamped so the pointer can never overrun the group.
         enq_lanes = (fetch_count_in > LANE_CNT_W'(SUPER_SCALAR_WIDTH))
                     ? LANE_CNT_W'(SUPER_SCALAR_WIDTH) : fetch_count_in;
      end
      deq_lanes = deq_fire ? decode_count_out : '0;

      for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
         wr_en[i] = LANE_CNT_W'(i) < enq_lanes;
      end

      if (flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(deq_lanes);
         tail_d  = tail_q + PTR_W'(enq_lanes);
         count_d = count_q + CNT_W'(enq_lanes) - CNT_W'(deq_lanes);
      end
   end

   // Lanes past the held entries are forced to NOP / pc 0 so decode never sees stale data.
   always_comb begin
      for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
         if (LANE_CNT_W'(i) < decode_count_out) begin
            decode_instrs_out[i] = rd_instrs[i];
            decode_pcs_out[i]    = rd_pcs[i];
         end else begin
            decode_instrs_out[i] = NOP_INSTR;
            decode_pcs_out[i]    = '0;
         end
      end
   end

   // Pointer and count registers; reset wins over flush and any handshake.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int W     = SUPER_SCALAR_WIDTH;
   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } exp_t;

   logic                clk_in = 1'b0;
   logic                rst_in;
   logic                flush_in;
   logic                fetch_valid_in;
   logic [W-1:0][31:0]  fetch_instrs_in;
   logic [2:0]          fetch_count_in;
   logic [63:0]         fetch_pc_in;
   logic                fq_ready_out;
   logic                decode_valid_out;
   logic [W-1:0][31:0]  decode_instrs_out;
   logic [W-1:0][63:0]  decode_pcs_out;
   logic [2:0]          decode_count_out;
   logic                decode_ready_in;
   logic [4:0]          occupancy_out;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic mon_en   = 1'b0;
   logic [63:0] nop_word = 64'h0000_0000_D503_201F;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .flush_in          (flush_in),
      .fetch_valid_in    (fetch_valid_in),
      .fetch_instrs_in   (fetch_instrs_in),
      .fetch_count_in    (fetch_count_in),
      .fetch_pc_in       (fetch_pc_in),
      .fq_ready_out      (fq_ready_out),
      .decode_valid_out  (decode_valid_out),
      .decode_instrs_out (decode_instrs_out),
      .decode_pcs_out    (decode_pcs_out),
      .decode_count_out  (decode_count_out),
      .decode_ready_in   (decode_ready_in),
      .occupancy_out     (occupancy_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // Monitor: compares DUT outputs against the model contents, then retires dequeued entries.
   always @(negedge clk_in) begin
      int sz;
      int nd;
      if (mon_en) begin
         sz = exp_q.size();
         nd = (sz < W) ? sz : W;
         chk("occupancy", 64'(occupancy_out), 64'(sz));
         chk("fq_ready", 64'(fq_ready_out), 64'((DEPTH - sz) >= W));
         chk("decode_valid", 64'(decode_valid_out), 64'(sz != 0));
         chk("decode_count", 64'(decode_count_out), 64'(nd));
         for (int i = 0; i < W; i++) begin
            if (i < sz) begin
               chk($sformatf("lane%0d_instr", i), 64'(decode_instrs_out[i]), 64'(exp_q[i].instr));
               chk($sformatf("lane%0d_pc", i), decode_pcs_out[i], exp_q[i].pc);
            end else begin
               chk($sformatf("lane%0d_nop", i), 64'(decode_instrs_out[i]), nop_word);
               chk($sformatf("lane%0d_pc0", i), decode_pcs_out[i], 64'd0);
            end
         end
         if (!rst_in && !flush_in && decode_ready_in && sz != 0) begin
            repeat (nd) void'(exp_q.pop_front());
         end
      end
   end

   // Stimulus: drive one cycle of inputs and record what the queue should have accepted.
   task automatic step(input logic v, input int n, input logic [63:0] pc,
                       input logic rdy, input logic fl, input logic rs);
      logic acc;
      rst_in          = rs;
      flush_in        = fl;
      fetch_valid_in  = v;
      fetch_count_in  = 3'(n);
      fetch_pc_in     = pc;
      decode_ready_in = rdy;
      for (int i = 0; i < W; i++) fetch_instrs_in[i] = $urandom;
      acc = v && ((DEPTH - exp_q.size()) >= W) && !fl && !rs;
      @(posedge clk_in);
      if (rs || fl) begin
         exp_q.delete();
      end else if (acc) begin
         for (int i = 0; i < n; i++) begin
            exp_q.push_back('{instr: fetch_instrs_in[i], pc: pc + 64'(4 * i)});
         end
      end
      #1;
   endtask

   initial begin
      logic [63:0] pc;
      rst_in = 1'b1;
      flush_in = 1'b0;
      fetch_valid_in = 1'b0;
      fetch_count_in = '0;
      fetch_pc_in = '0;
      decode_ready_in = 1'b0;
      fetch_instrs_in = '0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      mon_en = 1'b1;

      // Idle after reset.
      step(1'b0, 0, 64'd0, 1'b0, 1'b0, 1'b0);

      // Single full group, then fill to full, then an ignored group while full.
      step(1'b1, 4, 64'h1000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 0, 64'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4, 64'h1010, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4, 64'h1020, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4, 64'h1030, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4, 64'h9000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 0, 64'h9000, 1'b0, 1'b0, 1'b0);
      repeat (5) step(1'b0, 0, 64'd0, 1'b1, 1'b0, 1'b0);

      // Simultaneous enqueue and dequeue at occupancy 6.
      step(1'b1, 4, 64'h2000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2, 64'h2010, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4, 64'h2018, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 64'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 0, 64'd0, 1'b1, 1'b0, 1'b0);

      // Partial groups streaming across the pointer wrap.
      pc = 64'h3000;
      for (int c = 0; c < 20; c++) begin
         step(1'b1, 3, pc, 1'b1, 1'b0, 1'b0);
         pc += 64'd12;
      end
      repeat (3) step(1'b0, 0, 64'd0, 1'b1, 1'b0, 1'b0);

      // Flush at occupancy 10 with enqueue and dequeue requested.
      step(1'b1, 4, 64'h4000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4, 64'h4010, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2, 64'h4020, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4, 64'h5000, 1'b1, 1'b1, 1'b0);
      step(1'b0, 0, 64'd0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 0, 64'd0, 1'b1, 1'b0, 1'b0);

      // 64-bit pc wrap inside a group, then reset overriding an enqueue.
      step(1'b1, 4, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4, 64'h6000, 1'b0, 1'b0, 1'b1);
      step(1'b0, 0, 64'd0, 1'b0, 1'b0, 1'b0);

      // Random traffic.
      for (int c = 0; c < 800; c++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, W), {$urandom, $urandom},
              $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, 1'b0);
      end
      repeat (6) step(1'b0, 0, 64'd0, 1'b1, 1'b0, 1'b0);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
